// File: rtl/i2c_pkg.sv
// Shared types and helpers for the i2c_master slice: FSM states, quarter phases,
// the captured request payload and the quarter-length computation.
package i2c_pkg;

  localparam int unsigned ADDR_W = 7;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned BIT_W  = 3;

  typedef enum logic [3:0] {
    IDLE,
    START,
    ADDR,
    ADDR_ACK,
    WDATA,
    WDATA_ACK,
    RDATA,
    MACK,
    STOP
  } state_e;

  typedef enum logic [1:0] {
    Q0,
    Q1,
    Q2,
    Q3
  } phase_e;

  // Transaction request latched when start is accepted
  typedef struct packed {
    logic              op;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } i2c_req_t;

  function automatic int unsigned quarter_len(input int unsigned sys_clk,
                                              input int unsigned i2c_freq);
    return (sys_clk / i2c_freq) / 4;
  endfunction

  function automatic phase_e next_phase(input phase_e p);
    phase_e n;
    case (p)
      Q0:      n = Q1;
      Q1:      n = Q2;
      Q2:      n = Q3;
      default: n = Q0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/i2c_phase_gen.sv
// Quarter-phase timebase for one I2C bit slot: counts QLEN clocks per quarter
// and flags the first/last clock of each quarter and the end of the slot.
module i2c_phase_gen
  import i2c_pkg::*;
#(
  parameter int unsigned QLEN = 5
) (
  input  logic   clk,
  input  logic   resetn,
  input  logic   run,
  input  logic   hold,
  output phase_e phase,
  output logic   phase_first_c,
  output logic   phase_last_c,
  output logic   slot_end_c
);

  localparam int unsigned CW = (QLEN > 1) ? $clog2(QLEN) : 1;

  logic [CW-1:0] cnt;

  assign phase_first_c = (cnt == '0);
  assign phase_last_c  = (cnt == CW'(QLEN - 1));
  assign slot_end_c    = phase_last_c && (phase == Q3);

  // Counter parks at zero while idle so every transaction starts on Q0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!run) begin
      cnt   <= '0;
      phase <= Q0;
    end else if (!hold) begin
      if (phase_last_c) begin
        cnt   <= '0;
        phase <= next_phase(phase);
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/i2c_master.sv
// Single-byte I2C master: one addressed write or read per accepted start.
// Define I2C_MASTER_STRETCH_EN to let a slave stretch SCL via scl_i.
module i2c_master
  import i2c_pkg::*;
#(
  parameter int unsigned SYS_CLK  = 100_000_000,
  parameter int unsigned I2C_FREQ = 5_000_000
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              start,
  input  logic              op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              scl,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_o,
  output logic              sda_en,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              done,
  output logic              ack_err
);

  localparam int unsigned SLOT = SYS_CLK / I2C_FREQ;
  localparam int unsigned QLEN = quarter_len(SYS_CLK, I2C_FREQ);

  if ((SYS_CLK % I2C_FREQ) != 0 || (SLOT % 4) != 0 || SLOT < 8) begin : g_cfg_check
    $error("i2c_master: SYS_CLK/I2C_FREQ must be an integer multiple of 4 and >= 8");
  end

  state_e            state;
  i2c_req_t          req;
  logic [DATA_W-1:0] shreg;
  logic [BIT_W-1:0]  bit_cnt;
  logic              ack_bit;

  phase_e phase;
  logic   phase_first_c;
  logic   phase_last_c;
  logic   slot_end_c;
  logic   hold;
  logic   run;
  logic   q0_end;
  logic   q1_end;
  logic   q2_end;

  assign run    = (state != IDLE);
  assign q0_end = (phase == Q0) && phase_last_c;
  assign q1_end = (phase == Q1) && phase_last_c;
  assign q2_end = (phase == Q2) && phase_last_c;

  // The line is only ever pulled low; the drive value itself is constant
  assign sda_o = 1'b0;

`ifdef I2C_MASTER_STRETCH_EN
  // Freeze the slot at the SCL rise until the slave lets the line go high
  assign hold = (phase == Q2) && phase_first_c && !scl_i;
`else
  logic [1:0] unused_stretch;
  assign unused_stretch = {scl_i, phase_first_c};
  assign hold           = 1'b0;
`endif

  i2c_phase_gen #(
    .QLEN(QLEN)
  ) u_phase_gen (
    .clk          (clk),
    .resetn       (resetn),
    .run          (run),
    .hold         (hold),
    .phase        (phase),
    .phase_first_c(phase_first_c),
    .phase_last_c (phase_last_c),
    .slot_end_c   (slot_end_c)
  );

  // Outputs are updated on the last clock of the preceding quarter so that
  // they appear registered on the first clock of the quarter they belong to.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      scl     <= 1'b1;
      sda_en  <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ack_err <= 1'b0;
      rdata   <= '0;
      req     <= '0;
      shreg   <= '0;
      bit_cnt <= '0;
      ack_bit <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          scl    <= 1'b1;
          sda_en <= 1'b0;
          if (start && !done) begin
            req     <= '{op: op, addr: addr, wdata: wdata};
            ack_err <= 1'b0;
            busy    <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (q1_end) sda_en <= 1'b1;
          if (slot_end_c) begin
            scl     <= 1'b0;
            shreg   <= {req.addr, req.op};
            bit_cnt <= BIT_W'(7);
            state   <= ADDR;
          end
        end

        ADDR, WDATA: begin
          if (q0_end) sda_en <= ~shreg[DATA_W-1];
          if (q1_end) scl <= 1'b1;
          if (slot_end_c) begin
            scl     <= 1'b0;
            shreg   <= {shreg[DATA_W-2:0], 1'b0};
            bit_cnt <= bit_cnt - BIT_W'(1);
            if (bit_cnt == '0) state <= (state == ADDR) ? ADDR_ACK : WDATA_ACK;
          end
        end

        ADDR_ACK: begin
          if (q0_end) sda_en <= 1'b0;
          if (q1_end) scl <= 1'b1;
          if (q2_end) ack_bit <= sda_i;
          if (slot_end_c) begin
            scl <= 1'b0;
            if (ack_bit) begin
              ack_err <= 1'b1;
              sda_en  <= 1'b1;
              state   <= STOP;
            end else if (req.op) begin
              bit_cnt <= BIT_W'(7);
              state   <= RDATA;
            end else begin
              shreg   <= req.wdata;
              bit_cnt <= BIT_W'(7);
              state   <= WDATA;
            end
          end
        end

        WDATA_ACK: begin
          if (q0_end) sda_en <= 1'b0;
          if (q1_end) scl <= 1'b1;
          if (q2_end) ack_bit <= sda_i;
          if (slot_end_c) begin
            scl    <= 1'b0;
            sda_en <= 1'b1;
            if (ack_bit) ack_err <= 1'b1;
            state  <= STOP;
          end
        end

        RDATA: begin
          if (q0_end) sda_en <= 1'b0;
          if (q1_end) scl <= 1'b1;
          if (q2_end) shreg <= {shreg[DATA_W-2:0], sda_i};
          if (slot_end_c) begin
            scl     <= 1'b0;
            bit_cnt <= bit_cnt - BIT_W'(1);
            if (bit_cnt == '0) state <= MACK;
          end
        end

        // Single-byte read: always answer NACK to end the transfer
        MACK: begin
          sda_en <= 1'b0;
          if (q1_end) scl <= 1'b1;
          if (slot_end_c) begin
            scl    <= 1'b0;
            sda_en <= 1'b1;
            rdata  <= shreg;
            state  <= STOP;
          end
        end

        STOP: begin
          if (q1_end) scl <= 1'b1;
          if (q2_end) sda_en <= 1'b0;
          if (slot_end_c) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          scl    <= 1'b1;
          sda_en <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/i2c_master.md
I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 SHALL have parameter SYS_CLK, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter I2C_FREQ, default 5000000, SCL frequency in Hz; SYS_CLK/I2C_FREQ SHALL be a multiple of 4 and >=8, checked at elaboration.
REQ-003 clk  in  1  system clock; the only clock.
REQ-004 resetn  in  1  asynchronous active-low reset.
REQ-005 start  in  1  single-cycle transaction request; sampled only when busy=0.
REQ-006 op  in  1  direction: 1=read, 0=write; captured with start.
REQ-007 addr  in  7  target slave address; captured with start.
REQ-008 wdata  in  8  write byte; captured with start.
REQ-009 scl  out  1  SCL line value.
REQ-010 scl_i  in  1  sensed SCL line; used only under the REQ-030 macro.
REQ-011 sda_i  in  1  sensed SDA line.
REQ-012 sda_o  out  1  SDA drive value; always 0 when sda_en=1.
REQ-013 sda_en  out  1  SDA pull-low enable; 0 releases the line.
REQ-014 rdata  out  8  byte received on read; holds its value until the next read completes.
REQ-015 busy  out  1  transaction in progress.
REQ-016 done  out  1  one-cycle completion pulse.
REQ-017 ack_err  out  1  slave NACKed; valid with done; held until the next start.

Function
REQ-018 Bit slot: B = SYS_CLK/I2C_FREQ clocks, split into quarters Q0-Q3 of B/4 clocks each; scl=0 in Q0-Q1 and scl=1 in Q2-Q3, except in START.
REQ-019 Data bits: SDA changes on the first clock of Q1; SDA is sampled on the last clock of Q2; bits are sent and received MSB first.
REQ-020 FSM states: IDLE, START, ADDR, ADDR_ACK, WDATA, WDATA_ACK, RDATA, MACK, STOP.
REQ-021 IDLE: scl=1, sda released; accepted start sets busy=1 on the next cycle, clears ack_err, and moves to START.
REQ-022 START (1 slot): scl=1 throughout; SDA released in Q0-Q1 and low from Q2 onward; then ADDR.
REQ-023 ADDR (8 slots) transmits {addr, op}, then ADDR_ACK (1 slot, SDA released, sample taken): if sda_i=1, set ack_err=1 and go to STOP; if sda_i=0, go to WDATA when op=0 or RDATA when op=1.
REQ-024 WDATA (8 slots) transmits wdata, then WDATA_ACK: if sda_i=1, set ack_err=1; either way go to STOP.
REQ-025 RDATA (8 slots) shifts sda_i into a register with SDA released; MACK (1 slot) drives NACK (SDA released) and loads rdata; then STOP.
REQ-026 STOP (1 slot): SDA low in Q0-Q2, released at the first clock of Q3; at slot end: done=1 for one cycle, busy=0, return to IDLE.
REQ-027 Latency from the start sample to done: write or read completes in 20*B clocks (400 at defaults); an address NACK completes in 11*B clocks (220).
REQ-028 start asserted while busy=1 SHALL be ignored, with no queuing; start in the same cycle as done SHALL be ignored.

Reset
REQ-029 While resetn=0, asynchronously and including mid-transaction: state=IDLE, scl=1, sda_en=0, sda_o=0, busy=0, done=0, ack_err=0, rdata=0, quarter counter=0.

Configuration
REQ-030 With I2C_MASTER_STRETCH_EN defined, the quarter counter SHALL hold at the first clock of Q2 while scl_i=0 (clock stretching), so B grows by the stretch time; without the macro, scl_i SHALL be ignored and timing is fixed per REQ-018.

Structure
REQ-031 Package i2c_pkg SHALL hold the FSM state enum, a quarter-phase enum (Q0-Q3), and a function computing the quarter length from SYS_CLK and I2C_FREQ.
REQ-032 Sub-module i2c_phase_gen SHALL own the quarter counter and present phase, phase-first-clock, phase-last-clock and slot-end strobes.

Verification
REQ-033 Write: addr=0x50, op=0, wdata=0xA5, slave ACKs both bytes -> SDA bits 0xA0 then 0xA5, done at clock 400, ack_err=0.
REQ-034 Read: addr=0x50, op=1, slave returns 0x3C -> rdata=0x3C, master NACK observed in MACK, done at clock 400, ack_err=0.
REQ-035 Address NACK: no slave responds -> ack_err=1, STOP follows ADDR_ACK, done at clock 220, no data slots.
REQ-036 Stimulus: start pulsed at clock 100 of an active transfer -> ignored; a single done, and capture values unchanged.
REQ-037 Stimulus: resetn pulsed low during the 4th WDATA bit -> scl=1 and sda_en=0 in the same cycle; a new start after release completes normally.
REQ-038 With the macro defined, the slave holds scl_i=0 for 50 clocks in the 3rd address slot -> done arrives 50 clocks late and all bits are correct; without the macro, done stays at 400.
